mem_arbiter_2port: RTL and testbench

Two-requester arbiter and sequencer for the shared 16x8 single-port memory (read/write strobes, 4-bit address, 8-bit data, combinational read data). Requesters A and B issue independent read/write transactions over a req/ack handshake. The block grants one transaction at a time with round-robin fairness, drives the memory strobes for exactly one cycle, and returns read data with a one-cycle ack pulse.

---
 rtl/mem_arbiter_2port_pkg.sv | 17 +
 rtl/mem_arbiter_2port_if.sv | 50 +++++
 rtl/mem_arbiter_2port_rr_arbiter2.sv | 23 ++
 rtl/mem_arbiter_2port.sv | 105 ++++++++++
 tb/tb_mem_arbiter_2port.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_2port_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
// Requester ids double as indices into per-requester vectors in the top level.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam int DEFAULT_DW = 8;
  localparam int DEFAULT_AW = 4;

endpackage

// File: rtl/mem_arbiter_2port_if.sv
// Bundle of requester handshakes and memory-side signals for mem_arbiter_2port.
// slave is the arbiter's view; master is the requesters-plus-memory environment.
interface mem_arbiter_2port_if
  import mem_arb_pkg::*;
#(
  parameter int DW = DEFAULT_DW,
  parameter int AW = DEFAULT_AW
) ();

  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_ack;
  logic [DW-1:0] a_rdata;

  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_ack;
  logic [DW-1:0] b_rdata;

  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  mem_rdata,
    output a_ack, a_rdata, b_ack, b_rdata,
    output mem_read, mem_write, mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output mem_rdata,
    input  a_ack, a_rdata, b_ack, b_rdata,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    input  busy
  );

endinterface

// File: rtl/mem_arbiter_2port_rr_arbiter2.sv
// Combinational 2-way round-robin pick: a lone requester wins, a tie goes to
// whichever requester was not granted last.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic a_req,
  input  logic b_req,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = a_req | b_req;
    grant_id    = REQ_A;
    if (a_req && b_req) begin
      grant_id = ~last_grant;
    end else if (b_req) begin
      grant_id = REQ_B;
    end
  end

endmodule

// File: rtl/mem_arbiter_2port.sv
// Arbiter/sequencer for a shared single-port memory: IDLE picks a winner,
// ACCESS strobes the memory for one cycle, ACK pulses the winner's ack.
module mem_arbiter_2port
  import mem_arb_pkg::*;
#(
  parameter int DW = DEFAULT_DW,
  parameter int AW = DEFAULT_AW
) (
  input logic             clk,
  input logic             reset,
  mem_arbiter_2port_if.slave bus
);

  state_t        state_reg, state_next;
  logic          last_grant_reg;
  logic          id_reg;
  logic          we_reg;
  logic [AW-1:0] addr_reg;
  logic [DW-1:0] wdata_reg;

  logic          grant_valid;
  logic          grant_id;

  logic [1:0]    req_vec;
  logic [1:0]    we_vec;
  logic [AW-1:0] addr_vec  [2];
  logic [DW-1:0] wdata_vec [2];
  logic [DW-1:0] rdata_vec [2];
  logic [1:0]    ack_vec;

  assign req_vec = {bus.b_req, bus.a_req};
  assign we_vec  = {bus.b_we, bus.a_we};
  assign addr_vec[0]  = bus.a_addr;
  assign addr_vec[1]  = bus.b_addr;
  assign wdata_vec[0] = bus.a_wdata;
  assign wdata_vec[1] = bus.b_wdata;

  rr_arbiter2 u_rr (
    .a_req       (req_vec[REQ_A]),
    .b_req       (req_vec[REQ_B]),
    .last_grant  (last_grant_reg),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_valid) state_next = ACCESS;
      ACCESS:  state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request fields are captured once in IDLE so the requester may change them
  // right after its ack without disturbing the memory cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= REQ_B;
      id_reg         <= REQ_A;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && grant_valid) begin
        last_grant_reg <= grant_id;
        id_reg         <= grant_id;
        we_reg         <= we_vec[grant_id];
        addr_reg       <= addr_vec[grant_id];
        wdata_reg      <= wdata_vec[grant_id];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      logic [DW-1:0] rdata_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rdata_reg <= '0;
        end else if (state_reg == ACCESS && !we_reg && id_reg == 1'(gi)) begin
          rdata_reg <= bus.mem_rdata;
        end
      end

      assign rdata_vec[gi] = rdata_reg;
      assign ack_vec[gi]   = (state_reg == ACK) && (id_reg == 1'(gi));
    end
  endgenerate

  assign bus.mem_read  = (state_reg == ACCESS) && !we_reg;
  assign bus.mem_write = (state_reg == ACCESS) && we_reg;
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = wdata_reg;
  assign bus.a_ack     = ack_vec[REQ_A];
  assign bus.b_ack     = ack_vec[REQ_B];
  assign bus.a_rdata   = rdata_vec[REQ_A];
  assign bus.b_rdata   = rdata_vec[REQ_B];
  assign bus.busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_arbiter_2port.sv
// Self-checking bench for mem_arbiter_2port: table-driven transactions, hand
// sequences for timing corners, and an ack-ordered scoreboard.
module tb_mem_arbiter_2port;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  mem_arbiter_2port_if bus ();

  mem_arbiter_2port dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory model: combinational read, write on the rising edge.
  logic [7:0] mem_model [16];
  assign bus.mem_rdata = mem_model[bus.mem_addr];
  always @(posedge clk) begin
    if (bus.mem_write) mem_model[bus.mem_addr] <= bus.mem_wdata;
  end

  typedef struct {
    bit         id;
    bit         we;
    logic [7:0] rdata;
  } exp_t;

  typedef struct {
    bit         id;
    bit         we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
    logic [7:0] exp_a_rdata;
    logic [7:0] exp_b_rdata;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[7];
  vec_t v;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int a_ack_cyc = 0, b_ack_cyc = 0;
  int a_cnt = 0, b_cnt = 0;
  int a_cnt0, b_cnt0;
  bit prev_strobe = 1'b0;
  exp_t e_mon;
  bit id_mon;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input bit id, input bit we, input logic [7:0] rd);
    exp_t e;
    e.id = id;
    e.we = we;
    e.rdata = rd;
    exp_q.push_back(e);
  endtask

  function automatic logic [63:0] out_vec();
    return {31'd0, bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata,
            bus.a_ack, bus.b_ack, bus.a_rdata, bus.b_rdata, bus.busy};
  endfunction

  task automatic set_req(input bit side, input bit req, input bit we,
                         input logic [3:0] addr, input logic [7:0] wdata);
    if (side) begin
      bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata; bus.b_req = req;
    end else begin
      bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata; bus.a_req = req;
    end
  endtask

  // Raise req, hold until ack is seen, then drop it just after the ack cycle.
  task automatic do_txn(input bit side, input bit we, input logic [3:0] addr,
                        input logic [7:0] wdata);
    bit got = 1'b0;
    set_req(side, 1'b1, we, addr, wdata);
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      got = side ? bus.b_ack : bus.a_ack;
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ack_timeout: side %0d got no ack, required ack within 40 cycles", side);
    end
    @(posedge clk);
    #1;
    if (side) bus.b_req = 1'b0; else bus.a_req = 1'b0;
  endtask

  // Monitor: strobe sanity every cycle, ack order and read data via scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      check("ack_in_reset", {bus.a_ack, bus.b_ack}, 2'b00);
      prev_strobe = 1'b0;
    end else begin
      if (bus.mem_read || bus.mem_write) begin
        check("strobe_exclusive", bus.mem_read & bus.mem_write, 1'b0);
        check("strobe_one_cycle", prev_strobe, 1'b0);
      end
      prev_strobe = bus.mem_read | bus.mem_write;
      if (bus.a_ack || bus.b_ack) begin
        check("ack_both", bus.a_ack & bus.b_ack, 1'b0);
        id_mon = bus.b_ack;
        if (id_mon) begin b_ack_cyc = cyc; b_cnt++; end
        else begin a_ack_cyc = cyc; a_cnt++; end
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_ack: got ack id %0d, required no ack", id_mon);
        end else begin
          e_mon = exp_q.pop_front();
          check("grant_id", id_mon, e_mon.id);
          if (!e_mon.we)
            check("ack_rdata", id_mon ? bus.b_rdata : bus.a_rdata, e_mon.rdata);
          $display("txn: ack id=%0d we=%0d a_rdata=%02h b_rdata=%02h cyc=%0d",
                   id_mon, e_mon.we, bus.a_rdata, bus.b_rdata, cyc);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) mem_model[i] = 8'h00;
    mem_model[0] = 8'h5A;
    mem_model[2] = 8'h22;
    mem_model[5] = 8'h11;
    mem_model[7] = 8'h3C;
    set_req(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    set_req(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);

    //               id  we addr   wdata  exp_rd a_rdata b_rdata
    vecs[0] = '{1'b0, 1'b0, 4'd3, 8'h00, 8'hA5, 8'hA5, 8'h5A};
    vecs[1] = '{1'b0, 1'b0, 4'd5, 8'h00, 8'h11, 8'h11, 8'h5A};
    vecs[2] = '{1'b1, 1'b0, 4'd7, 8'h00, 8'h3C, 8'h11, 8'h3C};
    vecs[3] = '{1'b0, 1'b1, 4'd9, 8'h77, 8'h00, 8'h11, 8'h3C};
    vecs[4] = '{1'b1, 1'b1, 4'd7, 8'hC3, 8'h00, 8'h11, 8'h3C};
    vecs[5] = '{1'b0, 1'b0, 4'd9, 8'h00, 8'h77, 8'h77, 8'h3C};
    vecs[6] = '{1'b1, 1'b0, 4'd7, 8'h00, 8'hC3, 8'h77, 8'hC3};

    // Reset state
    @(posedge clk);
    #1;
    check("reset_outputs", out_vec(), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", bus.busy, 1'b0);
    @(posedge clk);
    #1;

    // Tie right after reset: A first, B three cycles later
    push_exp(1'b0, 1'b0, 8'h22);
    push_exp(1'b1, 1'b0, 8'h5A);
    fork
      do_txn(1'b0, 1'b0, 4'd2, 8'h00);
      do_txn(1'b1, 1'b0, 4'd0, 8'h00);
    join
    check("tie_ack_spacing", 64'(b_ack_cyc - a_ack_cyc), 64'd3);

    // Latency of a single write: strobe N+1, ack N+2, idle N+3
    push_exp(1'b0, 1'b1, 8'h00);
    set_req(1'b0, 1'b1, 1'b1, 4'd3, 8'hA5);
    @(negedge clk);
    check("lat_n_busy", {bus.busy, bus.mem_write}, 2'b00);
    @(negedge clk);
    check("lat_n1_strobe", {bus.busy, bus.mem_write, bus.a_ack}, 3'b110);
    check("lat_n1_addr_data", {bus.mem_addr, bus.mem_wdata}, {4'd3, 8'hA5});
    @(negedge clk);
    check("lat_n2_ack", {bus.busy, bus.mem_write, bus.a_ack, bus.b_ack}, 4'b1010);
    @(posedge clk);
    #1;
    bus.a_req = 1'b0;
    @(negedge clk);
    check("lat_n3_idle", bus.busy, 1'b0);
    @(posedge clk);
    #1;

    // Table-driven transactions
    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      push_exp(v.id, v.we, v.exp_rd);
      do_txn(v.id, v.we, v.addr, v.wdata);
      check($sformatf("vec%0d_a_rdata", i), bus.a_rdata, v.exp_a_rdata);
      check($sformatf("vec%0d_b_rdata", i), bus.b_rdata, v.exp_b_rdata);
    end

    // Continuous contention: 12 transactions, strictly alternating
    a_cnt0 = a_cnt;
    b_cnt0 = b_cnt;
    for (int k = 0; k < 6; k++) begin
      push_exp(1'b0, 1'b1, 8'h00);
      push_exp(1'b1, 1'b0, 8'h5A);
    end
    fork
      begin
        for (int ka = 0; ka < 6; ka++) do_txn(1'b0, 1'b1, 4'd12, 8'(8'h80 + ka));
      end
      begin
        for (int kb = 0; kb < 6; kb++) do_txn(1'b1, 1'b0, 4'd0, 8'h00);
      end
    join
    check("contention_a_count", 64'(a_cnt - a_cnt0), 64'd6);
    check("contention_b_count", 64'(b_cnt - b_cnt0), 64'd6);
    check("contention_last_write", mem_model[12], 8'h85);

    // Late request: B arrives during A's ACCESS cycle
    push_exp(1'b0, 1'b1, 8'h00);
    push_exp(1'b1, 1'b0, 8'h44);
    set_req(1'b0, 1'b1, 1'b1, 4'd4, 8'h44);
    @(negedge clk);
    check("late_n_busy", bus.busy, 1'b0);
    @(negedge clk);
    check("late_a_strobe", {bus.mem_write, bus.mem_addr}, {1'b1, 4'd4});
    set_req(1'b1, 1'b1, 1'b0, 4'd4, 8'h00);
    @(negedge clk);
    check("late_a_ack", {bus.a_ack, bus.b_ack}, 2'b10);
    @(posedge clk);
    #1;
    bus.a_req = 1'b0;
    @(negedge clk);
    check("late_idle", {bus.busy, bus.mem_read}, 2'b00);
    @(negedge clk);
    check("late_b_strobe", {bus.mem_read, bus.mem_addr}, {1'b1, 4'd4});
    @(negedge clk);
    check("late_b_ack", {bus.a_ack, bus.b_ack}, 2'b01);
    @(posedge clk);
    #1;
    bus.b_req = 1'b0;

    // Reset asserted in the ACCESS cycle of a tie won by A
    set_req(1'b0, 1'b1, 1'b0, 4'd5, 8'h00);
    set_req(1'b1, 1'b1, 1'b0, 4'd7, 8'h00);
    @(negedge clk);
    @(negedge clk);
    check("rst_access_winner", {bus.mem_read, bus.mem_addr}, {1'b1, 4'd5});
    #1;
    reset = 1'b1;
    #1;
    check("rst_async_outputs", out_vec(), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    push_exp(1'b0, 1'b0, 8'h11);
    push_exp(1'b1, 1'b0, 8'hC3);
    fork
      do_txn(1'b0, 1'b0, 4'd5, 8'h00);
      do_txn(1'b1, 1'b0, 4'd7, 8'h00);
    join
    check("rst_tie_spacing", 64'(b_ack_cyc - a_ack_cyc), 64'd3);

    @(negedge clk);
    check("final_a_rdata", bus.a_rdata, 8'h11);
    check("final_b_rdata", bus.b_rdata, 8'hC3);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required finish earlier");
    $fatal(1);
  end

endmodule
